// File: rtl/hv_enc_pkg.sv
// Shared HV encoder definitions: bundle sequencer states and the job-length limit helper.
package hv_enc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    TIE   = 3'd3,
    OUT   = 3'd4
  } bundle_seq_state_t;

  // Largest N whose worst-case count (plus the tie-break item) fits a signed counter.
  function automatic int unsigned max_bundle(input int unsigned counter_width,
                                             input bit tiebreak);
    return (32'd1 << (counter_width - 32'd1)) - 32'd1 - {31'd0, tiebreak};
  endfunction

endpackage

// File: rtl/bundler_set.sv
// Per-dimension signed up/down counters; each output bit is the sign-rule majority (count >= 0 -> 1).
module bundler_set #(
  parameter int HVDimension  = 512,
  parameter int CounterWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [HVDimension-1:0] hv_i,
  input  logic                   valid_i,
  input  logic                   clr_i,
  output logic [HVDimension-1:0] binarized_hv_o
);

  // Two's-complement counts held as raw bits; the MSB is the sign.
  logic [CounterWidth-1:0] cnt_q [HVDimension];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < HVDimension; i++) begin
      if (!rst_ni || clr_i) begin
        cnt_q[i] <= '0;
      end else if (valid_i) begin
        cnt_q[i] <= hv_i[i] ? cnt_q[i] + CounterWidth'(1) : cnt_q[i] - CounterWidth'(1);
      end
    end
  end

  always_comb begin
    binarized_hv_o = '0;
    for (int i = 0; i < HVDimension; i++) begin
      binarized_hv_o[i] = ~cnt_q[i][CounterWidth-1];
    end
  end

endmodule

// File: rtl/bundle_seq_ctrl.sv
// Bundle job sequencer: clears a bundler_set, feeds N HVs, presents the majority HV.
// Optional BUNDLE_SEQ_TIEBREAK_EN adds a TIE cycle for even N using the rotated first HV.
module bundle_seq_ctrl
  import hv_enc_pkg::*;
#(
  parameter int HVDimension  = 512,
  parameter int CounterWidth = 8,
  parameter int NumWidth     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [NumWidth-1:0]    num_bundle_i,
  output logic                   busy_o,
  output logic                   cfg_err_o,
  input  logic [HVDimension-1:0] hv_i,
  input  logic                   hv_valid_i,
  output logic                   hv_ready_o,
  output logic [HVDimension-1:0] hv_o,
  output logic                   hv_valid_o,
  input  logic                   hv_ready_i,
  output logic [NumWidth-1:0]    bundle_cnt_o
);

`ifdef BUNDLE_SEQ_TIEBREAK_EN
  localparam bit TieEn = 1'b1;
`else
  localparam bit TieEn = 1'b0;
`endif
  localparam int unsigned MaxBundle = max_bundle(CounterWidth, TieEn);

  bundle_seq_state_t     state_q, state_d;
  logic [NumWidth-1:0]   num_q, num_d;
  logic [NumWidth-1:0]   cnt_q, cnt_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [HVDimension-1:0] bnd_hv, bnd_bin;
  logic                   bnd_valid, bnd_clr;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_bundle_i != '0 && 32'(num_bundle_i) <= MaxBundle) begin
            num_d   = num_bundle_i;
            state_d = CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (hv_valid_i) begin
          cnt_d = cnt_q + NumWidth'(1);
          if (cnt_d == num_q) begin
`ifdef BUNDLE_SEQ_TIEBREAK_EN
            state_d = num_q[0] ? OUT : TIE;
`else
            state_d = OUT;
`endif
          end
        end
      end
`ifdef BUNDLE_SEQ_TIEBREAK_EN
      TIE: state_d = OUT;
`endif
      OUT: begin
        if (hv_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      num_q     <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef BUNDLE_SEQ_TIEBREAK_EN
  logic [HVDimension-1:0] first_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      first_q <= '0;
    end else if (state_q == ACCUM && hv_valid_i && cnt_q == '0) begin
      first_q <= hv_i;
    end
  end

  // The TIE item is the first HV rotated left by one, so it is not simply a repeat.
  assign bnd_hv    = (state_q == TIE) ? {first_q[HVDimension-2:0], first_q[HVDimension-1]} : hv_i;
  assign bnd_valid = (state_q == TIE) || (state_q == ACCUM && hv_valid_i);
`else
  assign bnd_hv    = hv_i;
  assign bnd_valid = (state_q == ACCUM) && hv_valid_i;
`endif
  assign bnd_clr = (state_q == CLEAR);

  bundler_set #(
    .HVDimension (HVDimension),
    .CounterWidth(CounterWidth)
  ) u_bundler (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .hv_i          (bnd_hv),
    .valid_i       (bnd_valid),
    .clr_i         (bnd_clr),
    .binarized_hv_o(bnd_bin)
  );

  assign busy_o       = (state_q != IDLE);
  assign cfg_err_o    = cfg_err_q;
  assign hv_ready_o   = (state_q == ACCUM);
  assign hv_valid_o   = (state_q == OUT);
  assign hv_o         = hv_valid_o ? bnd_bin : '0;
  assign bundle_cnt_o = cnt_q;

endmodule
